// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF->ID boundary.
//
// Contents:
//   FETCH_PC_W  default width of the PC, instruction and predicted-PC fields
//   FETCH_HP_W  default width of the BTB hit-position field
//   NOP_INSTR   instruction word presented to decode while the buffer is empty
//   fetch_t     one fetch bundle at the default widths, for neighbouring stages
//   fetch_empty helper returning an all-zero (NOP) bundle
package if_id_buffer_pkg;

  localparam int unsigned FETCH_PC_W = 32;
  localparam int unsigned FETCH_HP_W = 3;

  // All-zero encoding doubles as a NOP, so a cleared head is safe for decode.
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [FETCH_PC_W-1:0] instr;
    logic [FETCH_PC_W-1:0] pc_pre;
    logic [FETCH_HP_W-1:0] hitpos;
    logic                  hit;
  } fetch_t;

  function automatic fetch_t fetch_empty();
    fetch_t f;
    f        = '0;
    f.instr  = NOP_INSTR;
    return f;
  endfunction

endpackage

// File: rtl/if_id_buffer_sat_counter.sv
// Saturating event counter.
//
// Counts cycles in which inc is high, sticking at the all-ones value instead of
// wrapping. Cleared only by reset. Usable for any per-cycle stall statistic.
//
// Ports:
//   clk    system clock, rising edge
//   RST    synchronous active-low reset
//   inc    count this cycle
//   count  current count value
module if_id_buffer_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] SatMax = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != SatMax)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/if_id_buffer.sv
// Registered IF->ID boundary stage.
//
// A two-entry skid FIFO between fetch and decode. The head register drives all
// id_* outputs directly; the skid register catches the one fetch that arrives
// while decode stalls, so if_ready depends only on registered occupancy and
// halt, never on id_ready. Flush drops every held entry. A saturating counter
// tracks cycles where decode was ready but starved.
//
// Ports:
//   clk, RST                      clock, synchronous active-low reset
//   if_valid, if_pc, if_instr,    fetch bundle offered by the fetch stage
//   if_pc_pre, if_hitpos, if_hit
//   if_ready                      buffer can accept (fetch stalls when low)
//   flush                         discard all held entries
//   halt                          stop accepting, keep draining
//   id_ready                      decode takes the head entry this cycle
//   id_valid, id_pc, id_instr,    head entry; data fields are zero when empty
//   id_pc_pre, id_hitpos, id_hit
//   bubble_cnt                    saturating count of decode-starved cycles
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned PC_W  = FETCH_PC_W,
  parameter int unsigned HP_W  = FETCH_HP_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  // fetch side
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  input  logic [PC_W-1:0]  if_instr,
  input  logic [PC_W-1:0]  if_pc_pre,
  input  logic [HP_W-1:0]  if_hitpos,
  input  logic             if_hit,
  output logic             if_ready,
  // control
  input  logic             flush,
  input  logic             halt,
  // decode side
  input  logic             id_ready,
  output logic             id_valid,
  output logic [PC_W-1:0]  id_pc,
  output logic [PC_W-1:0]  id_instr,
  output logic [PC_W-1:0]  id_pc_pre,
  output logic [HP_W-1:0]  id_hitpos,
  output logic             id_hit,
  // statistics
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_pre;
    logic [HP_W-1:0] hitpos;
    logic            hit;
  } entry_t;

  // Cleared entry: every field zero, instruction is the NOP encoding.
  localparam entry_t EmptyEntry = '{
    pc:     '0,
    instr:  PC_W'(NOP_INSTR),
    pc_pre: '0,
    hitpos: '0,
    hit:    1'b0
  };

  // Occupancy encoding.
  localparam logic [1:0] OccEmpty = 2'd0;
  localparam logic [1:0] OccOne   = 2'd1;
  localparam logic [1:0] OccFull  = 2'd2;

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  entry_t     in_entry;
  logic       push;
  logic       pop;

  assign in_entry = '{
    pc:     if_pc,
    instr:  if_instr,
    pc_pre: if_pc_pre,
    hitpos: if_hitpos,
    hit:    if_hit
  };

  // Registered-state-only ready; decode backpressure is absorbed by the skid.
  assign if_ready = (count_q != OccFull) & ~halt;
  assign id_valid = (count_q != OccEmpty);

  assign push = if_valid & if_ready & ~flush;
  assign pop  = id_valid & id_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      count_d = OccEmpty;
      head_d  = EmptyEntry;
      skid_d  = EmptyEntry;
    end else begin
      case (count_q)
        OccEmpty: begin
          if (push) begin
            head_d  = in_entry;
            count_d = OccOne;
          end
        end
        OccOne: begin
          if (push && !pop) begin
            skid_d  = in_entry;
            count_d = OccFull;
          end else if (push && pop) begin
            head_d  = in_entry;
          end else if (pop) begin
            head_d  = EmptyEntry;
            count_d = OccEmpty;
          end
        end
        OccFull: begin
          // if_ready is low here, so push cannot occur.
          if (pop) begin
            head_d  = skid_q;
            skid_d  = EmptyEntry;
            count_d = OccOne;
          end
        end
        default: begin
          // Unreachable encoding; recover to empty.
          count_d = OccEmpty;
          head_d  = EmptyEntry;
          skid_d  = EmptyEntry;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      count_q <= OccEmpty;
      head_q  <= EmptyEntry;
      skid_q  <= EmptyEntry;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign id_pc     = head_q.pc;
  assign id_instr  = head_q.instr;
  assign id_pc_pre = head_q.pc_pre;
  assign id_hitpos = head_q.hitpos;
  assign id_hit    = head_q.hit;

  // Decode wanted work but had none; counts during flush cycles too.
  if_id_buffer_sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .RST   (RST),
    .inc   (id_ready & ~id_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned HP_W   = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int          BubMax = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             RST = 1'b0;
  logic             if_valid = 1'b0;
  logic [PC_W-1:0]  if_pc = '0;
  logic [PC_W-1:0]  if_instr = '0;
  logic [PC_W-1:0]  if_pc_pre = '0;
  logic [HP_W-1:0]  if_hitpos = '0;
  logic             if_hit = 1'b0;
  logic             if_ready;
  logic             flush = 1'b0;
  logic             halt = 1'b0;
  logic             id_ready = 1'b0;
  logic             id_valid;
  logic [PC_W-1:0]  id_pc;
  logic [PC_W-1:0]  id_instr;
  logic [PC_W-1:0]  id_pc_pre;
  logic [HP_W-1:0]  id_hitpos;
  logic             id_hit;
  logic [CNT_W-1:0] bubble_cnt;

  always #5 clk = ~clk;

  if_id_buffer #(
    .PC_W  (PC_W),
    .HP_W  (HP_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_pc_pre  (if_pc_pre),
    .if_hitpos  (if_hitpos),
    .if_hit     (if_hit),
    .if_ready   (if_ready),
    .flush      (flush),
    .halt       (halt),
    .id_ready   (id_ready),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .id_pc_pre  (id_pc_pre),
    .id_hitpos  (id_hitpos),
    .id_hit     (id_hit),
    .bubble_cnt (bubble_cnt)
  );

  // Reference model: a plain queue of accepted bundles plus an occupancy count
  // and a saturating bubble count.
  fetch_t exp_q[$];
  int     occ = 0;
  int     bub = 0;
  bit     started = 1'b0;
  int     n_total = 0;
  int     n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model update at each rising edge, from the inputs the bench is driving.
  initial forever begin
    bit     acc;
    bit     rel;
    fetch_t f;
    @(posedge clk);
    if (!RST) begin
      exp_q.delete();
      occ = 0;
      bub = 0;
    end else begin
      if (id_ready && occ == 0 && bub < BubMax) bub++;
      if (flush) begin
        exp_q.delete();
        occ = 0;
      end else begin
        acc = if_valid && (occ != 2) && !halt;
        rel = (occ != 0) && id_ready;
        if (acc) begin
          f = '{pc: if_pc, instr: if_instr, pc_pre: if_pc_pre, hitpos: if_hitpos, hit: if_hit};
          exp_q.push_back(f);
        end
        occ = occ + int'(acc) - int'(rel);
      end
    end
    started = 1'b1;
  end

  // Monitor: samples the DUT mid-cycle, compares, and retires delivered entries.
  initial forever begin
    fetch_t head;
    @(negedge clk);
    if (started) begin
      head = '{pc: id_pc, instr: id_instr, pc_pre: id_pc_pre, hitpos: id_hitpos, hit: id_hit};
      check("if_ready", 128'(if_ready), 128'((occ != 2) && !halt));
      check("id_valid", 128'(id_valid), 128'(occ != 0));
      check("bubble_cnt", 128'(bubble_cnt), 128'(bub));
      if (occ != 0) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 128'(exp_q.size()), 128'(occ));
        end else begin
          check("head", 128'(head), 128'(exp_q[0]));
          if (id_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("empty_zero", 128'(head), 128'(fetch_empty()));
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl,
                       input bit hl, input bit rst_n);
    if_valid  = v;
    if_pc     = pc;
    if_instr  = $urandom;
    if_pc_pre = $urandom;
    if_hitpos = 3'($urandom);
    if_hit    = 1'($urandom);
    id_ready  = rdy;
    flush     = fl;
    halt      = hl;
    RST       = rst_n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    drive(0, 32'h0, 0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 0);
    // Streaming with decode always ready.
    drive(1, 32'h00, 1, 0, 0, 1);
    drive(1, 32'h04, 1, 0, 0, 1);
    drive(1, 32'h08, 1, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0, 1);
    // Backpressure: 0x18 refused while full, accepted when re-presented.
    drive(1, 32'h10, 0, 0, 0, 1);
    drive(1, 32'h14, 0, 0, 0, 1);
    drive(1, 32'h18, 0, 0, 0, 1);
    drive(1, 32'h18, 1, 0, 0, 1);
    drive(1, 32'h18, 1, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0, 1);
    // Flush with full buffer and a concurrent fetch.
    drive(1, 32'h20, 0, 0, 0, 1);
    drive(1, 32'h24, 0, 0, 0, 1);
    drive(1, 32'h28, 0, 1, 0, 1);
    drive(0, 32'h0, 0, 0, 0, 1);
    // Reset wins over flush and push.
    drive(1, 32'h2c, 0, 0, 0, 1);
    drive(1, 32'h30, 0, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 0, 1);
    // Halt drains held entries without accepting new ones.
    drive(1, 32'h40, 0, 0, 0, 1);
    drive(1, 32'h44, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 32'h48, 1, 0, 1, 1);
    drive(1, 32'h48, 1, 0, 0, 1);
    drive(0, 32'h0, 1, 0, 0, 1);
    // Starved decode: bubble counter saturates.
    for (int i = 0; i < 20; i++) drive(0, 32'h0, 1, 0, 0, 1);
    // Prediction fields pass through unchanged.
    if_valid  = 1'b1;
    if_pc     = 32'h50;
    if_instr  = 32'h1234_5678;
    if_pc_pre = 32'h100;
    if_hitpos = 3'd5;
    if_hit    = 1'b1;
    id_ready  = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 32'h0, 1, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom), $urandom & 32'hffff_fffc, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 63) != 0));
    end
    for (int i = 0; i < 4; i++) drive(0, 32'h0, 1, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
